// File: rtl/fb_scan.sv
// Double-buffered 256x256 RGB332 frame buffer: captures renderer pixel writes into
// the back buffer, scans the front buffer out with fixed video timing, swaps in vblank.
module fb_scan #(
    parameter int H_TOTAL  = 384,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int V_START  = 16,
    parameter int HS_START = 304,
    parameter int HS_LEN   = 32,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_pix,
    input  logic [7:0] wr_h,
    input  logic [7:0] wr_v,
    input  logic [2:0] wr_r,
    input  logic [2:0] wr_g,
    input  logic [1:0] wr_b,
    input  logic       wr_done,
    input  logic       wr_frame,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       hs,
    output logic       vs,
    output logic       hblank,
    output logic       vblank,
    output logic       front
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] HS_B   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
    localparam logic [8:0] VS_B   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_START + VS_LEN);
    localparam logic [7:0] V_OFF  = 8'(V_START);

    // Address = {buffer, row, col}; contents are never reset.
    logic [7:0] mem [0:131071];

    logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       front_q, front_d, swap_q, swap_d;
    logic       done_q, frame_q;
    logic [7:0] rd_q;
    logic       act1_q, hs1_q, vs1_q, hb1_q, vb1_q;
    logic [2:0] r_q, g_q;
    logic [1:0] b_q;
    logic       hs_q, vs_q, hb_q, vb_q;

    logic       hwrap, swap_pt, frame_edge, wr_edge;
    logic [7:0] rd_row;

    always_comb begin
        hwrap      = (hcnt_q == H_LAST);
        hcnt_d     = hwrap ? 9'd0 : hcnt_q + 9'd1;
        vcnt_d     = vcnt_q;
        if (hwrap) vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
        swap_pt    = ce_pix && hwrap && (vcnt_q == V_ACT - 9'd1);
        frame_edge = wr_frame && !frame_q;
        wr_edge    = wr_done && !done_q;
        rd_row     = vcnt_q[7:0] + V_OFF;
        front_d    = front_q;
        swap_d     = swap_q || frame_edge;
        // A frame edge landing on the swap point counts for this swap.
        if (swap_pt && (swap_q || frame_edge)) begin
            front_d = !front_q;
            swap_d  = 1'b0;
        end
    end

    // Write always targets the buffer that is back before this edge.
    always_ff @(posedge clk) begin
        if (rst_n && wr_edge) mem[{!front_q, wr_v, wr_h}] <= {wr_b, wr_g, wr_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            front_q <= 1'b0;
            swap_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
            rd_q    <= '0;
            act1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            hb1_q   <= 1'b0;
            vb1_q   <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hb_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            done_q  <= wr_done;
            frame_q <= wr_frame;
            front_q <= front_d;
            swap_q  <= swap_d;
            if (ce_pix) begin
                hcnt_q <= hcnt_d;
                vcnt_q <= vcnt_d;
                rd_q   <= mem[{front_q, rd_row, hcnt_q[7:0]}];
                act1_q <= (hcnt_q < 9'd256) && (vcnt_q < V_ACT);
                hs1_q  <= (hcnt_q >= HS_B) && (hcnt_q < HS_E);
                vs1_q  <= (vcnt_q >= VS_B) && (vcnt_q < VS_E);
                hb1_q  <= (hcnt_q >= 9'd256);
                vb1_q  <= (vcnt_q >= V_ACT);
                r_q    <= act1_q ? rd_q[2:0] : 3'd0;
                g_q    <= act1_q ? rd_q[5:3] : 3'd0;
                b_q    <= act1_q ? rd_q[7:6] : 2'd0;
                hs_q   <= hs1_q;
                vs_q   <= vs1_q;
                hb_q   <= hb1_q;
                vb_q   <= vb1_q;
            end
        end
    end

    assign r      = r_q;
    assign g      = g_q;
    assign b      = b_q;
    assign hs     = hs_q;
    assign vs     = vs_q;
    assign hblank = hb_q;
    assign vblank = vb_q;
    assign front  = front_q;

endmodule

// File: tb/tb_fb_scan.sv
// Directed bench for fb_scan with a short frame (40 lines) and V_START chosen so rows wrap.
module tb_fb_scan;

    localparam int HT = 384;
    localparam int VT = 40;

    logic       clk = 1'b0;
    logic       rst_n, ce_pix;
    logic [7:0] wr_h, wr_v;
    logic [2:0] wr_r, wr_g;
    logic [1:0] wr_b;
    logic       wr_done, wr_frame;
    logic [2:0] r, g;
    logic [1:0] b;
    logic       hs, vs, hblank, vblank, front;
    logic [11:0] outs;

    int tests = 0;
    int fails = 0;
    int m_h = 0;
    int m_v = 0;

    fb_scan #(
        .V_TOTAL(VT), .V_ACTIVE(24), .V_START(250), .VS_START(30), .VS_LEN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix),
        .wr_h(wr_h), .wr_v(wr_v), .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .wr_done(wr_done), .wr_frame(wr_frame),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
        .hblank(hblank), .vblank(vblank), .front(front)
    );

    assign outs = {r, g, b, hs, vs, hblank, vblank};

    always #5 clk = ~clk;

    // Reference scan position, advanced independently of the DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_h <= 0;
            m_v <= 0;
        end else if (ce_pix) begin
            if (m_h == HT - 1) begin
                m_h <= 0;
                m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    typedef struct {
        string       name;
        int          h;
        int          v;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input string name, input int h, input int v,
                                input logic [2:0] er, input logic [2:0] eg, input logic [1:0] eb,
                                input logic ehs, input logic evs, input logic ehb, input logic evb);
        vec_t t;
        t.name = name;
        t.h    = h;
        t.v    = v;
        t.exp  = {er, eg, eb, ehs, evs, ehb, evb};
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_h == h && m_v == v) && k < 20000);
        if (!(m_h == h && m_v == v)) begin
            fails++;
            $display("FAIL wait_pos: position %0d,%0d not reached, at %0d,%0d", h, v, m_h, m_v);
        end
    endtask

    // Output for position (h,v) is visible once the scan is two pixels further on.
    task automatic check_vec(input vec_t t);
        wait_pos(t.h + 2, t.v);
        check(t.name, {4'd0, outs}, {4'd0, t.exp});
    endtask

    task automatic do_write(input int h, input int v, input int wr, input int wg, input int wb);
        @(negedge clk);
        wr_h    = 8'(h);
        wr_v    = 8'(v);
        wr_r    = 3'(wr);
        wr_g    = 3'(wg);
        wr_b    = 2'(wb);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        wr_frame = 1'b1;
        @(negedge clk);
        wr_frame = 1'b0;
    endtask

    vec_t vecs_a[10];
    vec_t vecs_b[2];
    int   hs_at, hb_at, n;
    logic [11:0] snap;

    initial begin
        // Frame 1 shows buffer 1; display line L reads row (L+250) mod 256.
        vecs_a[0] = mk("held_col0",  0,   4, 3'd6, 3'd6, 2'd2, 0, 0, 0, 0);
        vecs_a[1] = mk("held_col1",  1,   4, 3'd1, 3'd1, 2'd1, 0, 0, 0, 0);
        vecs_a[2] = mk("held_col4",  4,   4, 3'd1, 3'd1, 2'd1, 0, 0, 0, 0);
        vecs_a[3] = mk("pix_c7",     5,   4, 3'd7, 3'd0, 2'd3, 0, 0, 0, 0);
        vecs_a[4] = mk("hblank_blk", 256, 4, 3'd0, 3'd0, 2'd0, 0, 0, 1, 0);
        vecs_a[5] = mk("hs_before",  303, 4, 3'd0, 3'd0, 2'd0, 0, 0, 1, 0);
        vecs_a[6] = mk("hs_first",   304, 4, 3'd0, 3'd0, 2'd0, 1, 0, 1, 0);
        vecs_a[7] = mk("hs_last",    335, 4, 3'd0, 3'd0, 2'd0, 1, 0, 1, 0);
        vecs_a[8] = mk("hs_after",   336, 4, 3'd0, 3'd0, 2'd0, 0, 0, 1, 0);
        vecs_a[9] = mk("row_wrap",   7,  10, 3'd1, 3'd2, 2'd3, 0, 0, 0, 0);
        vecs_b[0] = mk("vblank_vs",  5,  30, 3'd0, 3'd0, 2'd0, 0, 1, 0, 1);
        vecs_b[1] = mk("vs_end",     5,  32, 3'd0, 3'd0, 2'd0, 0, 0, 0, 1);

        rst_n = 1'b0; ce_pix = 1'b1;
        wr_h = '0; wr_v = '0; wr_r = '0; wr_g = '0; wr_b = '0;
        wr_done = 1'b0; wr_frame = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {4'd0, outs}, 16'd0);
        check("reset_front", {15'd0, front}, 16'd0);

        rst_n = 1'b1;
        hs_at = 0; hb_at = 0; n = 0;
        while ((hs_at == 0 || hb_at == 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (hs && hs_at == 0) hs_at = n;
            if (hblank && hb_at == 0) hb_at = n;
        end
        check("hs_rise_clks", 16'(hs_at), 16'd306);
        check("hblank_rise_clks", 16'(hb_at), 16'd258);

        // Scanout frozen while writes still land in the back buffer.
        @(negedge clk);
        snap = outs;
        ce_pix = 1'b0;
        for (int c = 1; c <= 4; c++) do_write(c, 254, 1, 1, 1);
        do_write(5, 254, 7, 0, 3);
        @(negedge clk);
        check("ce_low_static", {4'd0, outs}, {4'd0, snap});
        check("ce_low_hs_held", {15'd0, hs}, 16'd1);
        ce_pix = 1'b1;

        // wr_done held high while the column advances: only column 0 is written.
        @(negedge clk);
        wr_v = 8'd254; wr_h = 8'd0; wr_r = 3'd6; wr_g = 3'd6; wr_b = 2'd2;
        wr_done = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            wr_h = 8'(c);
        end
        @(negedge clk);
        wr_done = 1'b0;
        do_write(7, 4, 1, 2, 3);
        do_write(5, 24, 7, 7, 3);

        wait_pos(0, 10);
        pulse_frame();
        wait_pos(HT - 1, 23);
        check("no_early_swap", {15'd0, front}, 16'd0);
        @(posedge clk);
        #1;
        check("swap_at_point", {15'd0, front}, 16'd1);

        // Now back = buffer 0; displayed buffer 1 must stay unchanged.
        do_write(5, 254, 1, 2, 0);
        for (int i = 0; i < 10; i++) check_vec(vecs_a[i]);

        wait_pos(0, 12);
        pulse_frame();
        wait_pos(0, 14);
        pulse_frame();
        wait_pos(HT - 1, 23);
        check("two_pulse_pre", {15'd0, front}, 16'd1);
        wait_pos(0, 24);
        check("two_pulse_one_swap", {15'd0, front}, 16'd0);
        for (int i = 0; i < 2; i++) check_vec(vecs_b[i]);

        check_vec(mk("buf0_pix", 5, 4, 3'd1, 3'd2, 2'd0, 0, 0, 0, 0));

        // Frame edge and pixel write on the swap-point cycle itself.
        wait_pos(HT - 1, 23);
        wr_frame = 1'b1;
        wr_done  = 1'b1;
        wr_h = 8'd9; wr_v = 8'd254; wr_r = 3'd3; wr_g = 3'd4; wr_b = 2'd1;
        @(posedge clk);
        #1;
        check("simul_swap", {15'd0, front}, 16'd1);
        @(negedge clk);
        wr_frame = 1'b0;
        wr_done  = 1'b0;
        check_vec(mk("simul_write_old_back", 9, 4, 3'd3, 3'd4, 2'd1, 0, 0, 0, 0));
        check_vec(mk("buf1_persist", 5, 4 + 0, 3'd7, 3'd0, 2'd3, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
